// File: rtl/nim_rate_scaler.sv
// rtl/nim_rate_scaler.sv - per-channel rising-edge rate scaler with gated windows
// Optional running totals are built when NIM_SCALER_TOTALS_EN is defined.
module nim_rate_scaler #(
   parameter int N_CH       = 16,
   parameter int CNT_W      = 32,
   parameter int TOT_W      = 48,
   parameter int GATE_TICKS = 100_000_000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_CH-1:0]         trig_in,
   input  logic                    enable,
   input  logic                    clear,
   output logic [N_CH*CNT_W-1:0]   rates_out,
   output logic [N_CH*TOT_W-1:0]   totals_out,
   output logic                    gate_done,
   output logic [31:0]             gate_count
);

   localparam int               TICK_W    = $clog2(GATE_TICKS);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(GATE_TICKS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [N_CH-1:0]        trig_q;
   logic [N_CH-1:0]        rise;
   logic [TICK_W-1:0]      tick_q;
   logic [CNT_W-1:0]       live_q [N_CH];
   logic [CNT_W-1:0]       live_d [N_CH];
   logic [N_CH*CNT_W-1:0]  rates_q;
   logic [31:0]            gate_count_q;
   logic                   close_q;
   logic                   done_q;

   // live_d already includes this cycle's edge, so the closing edge lands in the closing window
   always_comb begin
      rise = trig_in & ~trig_q;
      for (int i = 0; i < N_CH; i++) begin
         live_d[i] = (rise[i] && live_q[i] != CNT_MAX) ? live_q[i] + CNT_W'(1) : live_q[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trig_q       <= '1;
         tick_q       <= '0;
         live_q       <= '{default: '0};
         rates_q      <= '0;
         gate_count_q <= '0;
         close_q      <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         trig_q <= trig_in;
         if (clear) begin
            tick_q       <= '0;
            live_q       <= '{default: '0};
            rates_q      <= '0;
            gate_count_q <= '0;
            close_q      <= 1'b0;
            done_q       <= 1'b0;
         end else begin
            done_q  <= close_q;
            close_q <= 1'b0;
            if (enable) begin
               if (tick_q == TICK_LAST) begin
                  tick_q       <= '0;
                  gate_count_q <= gate_count_q + 32'd1;
                  close_q      <= 1'b1;
                  for (int i = 0; i < N_CH; i++) begin
                     rates_q[i*CNT_W +: CNT_W] <= live_d[i];
                     live_q[i]                 <= '0;
                  end
               end else begin
                  tick_q <= tick_q + TICK_W'(1);
                  live_q <= live_d;
               end
            end
         end
      end
   end

   assign rates_out  = rates_q;
   assign gate_count = gate_count_q;
   assign gate_done  = done_q;

`ifdef NIM_SCALER_TOTALS_EN
   localparam logic [TOT_W-1:0] TOT_MAX = '1;

   logic [TOT_W-1:0] tot_q [N_CH];
   logic [TOT_W-1:0] tot_d [N_CH];

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         tot_d[i] = (rise[i] && tot_q[i] != TOT_MAX) ? tot_q[i] + TOT_W'(1) : tot_q[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tot_q <= '{default: '0};
      end else if (clear) begin
         tot_q <= '{default: '0};
      end else if (enable) begin
         tot_q <= tot_d;
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_tot
      assign totals_out[g*TOT_W +: TOT_W] = tot_q[g];
   end
`else
   assign totals_out = '0;
`endif

endmodule
